// File: rtl/pwr_dvfs_pkg.sv
// Shared types for the DVFS performance-mode controller: operating points, sequencer states,
// error-source encoding and a constant helper used to size the shared wait timer.
package pwr_dvfs_pkg;

   typedef enum logic [1:0] {
      PERF_LOW   = 2'b00,
      PERF_MED   = 2'b01,
      PERF_HIGH  = 2'b10,
      PERF_TURBO = 2'b11
   } perf_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_V_UP,
      ST_SETTLE,
      ST_F_UP,
      ST_F_DN,
      ST_V_DN,
      ST_DONE
   } dvfs_state_e;

   localparam logic ERR_SRC_VREG = 1'b0;
   localparam logic ERR_SRC_PLL  = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pwr_dvfs_wait_timer.sv
// Clear/enable up-counter with terminal-count compare, shared by the settle delay and handshake timeouts.
// tc is combinational from the registered count; clr has priority over en.
module pwr_dvfs_wait_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] tc_value,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign tc = (count == tc_value);

endmodule

// File: rtl/pwr_dvfs_controller.sv
// DVFS sequencer: raises voltage before frequency going up, drops frequency before voltage going down.
// Up latency from accept is 2+SETTLE+2+1 cycles with prompt acks; requests wait (req_ready=0) while busy or in error.
module pwr_dvfs_controller
   import pwr_dvfs_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_mode,
   output logic       req_ready,
   output logic       vreg_req,
   output logic [1:0] vreg_level,
   input  logic       vreg_ack,
   output logic       pll_req,
   output logic [1:0] pll_mode,
   input  logic       pll_lock,
   output logic [1:0] performance_mode,
   output logic       busy,
   output logic       error,
   output logic       err_src,
   input  logic       err_clr
);

   localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

   dvfs_state_e      state;
   logic [1:0]       target;
   logic             vreg_done;
   logic             pll_done;
   logic             vreg_wait;
   logic             pll_wait;
   logic             tmr_clr;
   logic             tmr_tc;
   logic [TMR_W-1:0] tmr_tc_value;

   // Handshake responses only count while our own request is up.
   assign vreg_done = vreg_req && vreg_ack;
   assign pll_done  = pll_req && pll_lock;
   assign vreg_wait = (state == ST_V_UP) || (state == ST_V_DN);
   assign pll_wait  = (state == ST_F_UP) || (state == ST_F_DN);

   assign req_ready = (state == ST_IDLE) && !error;

   // Timer restarts on every entry into a timed state.
   always_comb begin
      tmr_clr = 1'b1;
      case (state)
         ST_V_UP, ST_V_DN: tmr_clr = vreg_done;
         ST_F_UP, ST_F_DN: tmr_clr = pll_done;
         ST_SETTLE:        tmr_clr = tmr_tc;
         default:          tmr_clr = 1'b1;
      endcase
   end

   assign tmr_tc_value = (state == ST_SETTLE) ? TMR_W'(SETTLE_CYCLES - 1)
                                              : TMR_W'(TIMEOUT_CYCLES - 1);

   pwr_dvfs_wait_timer #(.WIDTH(TMR_W)) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .en       (busy),
      .tc_value (tmr_tc_value),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         target           <= PERF_LOW;
         performance_mode <= PERF_LOW;
         vreg_level       <= PERF_LOW;
         pll_mode         <= PERF_LOW;
         vreg_req         <= 1'b0;
         pll_req          <= 1'b0;
         busy             <= 1'b0;
         error            <= 1'b0;
         err_src          <= ERR_SRC_VREG;
      end else begin
         if (err_clr) begin
            error <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  target <= req_mode;
                  busy   <= 1'b1;
                  if (req_mode > performance_mode) begin
                     vreg_req   <= 1'b1;
                     vreg_level <= req_mode;
                     state      <= ST_V_UP;
                  end else if (req_mode < performance_mode) begin
                     pll_req  <= 1'b1;
                     pll_mode <= req_mode;
                     state    <= ST_F_DN;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_V_UP: begin
               if (vreg_done) begin
                  vreg_req <= 1'b0;
                  state    <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (tmr_tc) begin
                  pll_req  <= 1'b1;
                  pll_mode <= target;
                  state    <= ST_F_UP;
               end
            end
            ST_F_UP: begin
               if (pll_done) begin
                  pll_req <= 1'b0;
                  state   <= ST_DONE;
               end
            end
            ST_F_DN: begin
               if (pll_done) begin
                  pll_req    <= 1'b0;
                  vreg_req   <= 1'b1;
                  vreg_level <= target;
                  state      <= ST_V_DN;
               end
            end
            ST_V_DN: begin
               if (vreg_done) begin
                  vreg_req <= 1'b0;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               performance_mode <= target;
               busy             <= 1'b0;
               state            <= ST_IDLE;
            end
            default: begin
               vreg_req <= 1'b0;
               pll_req  <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase

         // Placed last so a timeout overrides a coincident err_clr; levels and mode are left as-is.
         if ((vreg_wait && !vreg_done && tmr_tc) || (pll_wait && !pll_done && tmr_tc)) begin
            vreg_req <= 1'b0;
            pll_req  <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_src  <= pll_wait ? ERR_SRC_PLL : ERR_SRC_VREG;
            state    <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_pwr_dvfs_controller.sv
// Bench for pwr_dvfs_controller: randomized regulator/PLL responder checked against a phase-level model.
module tb_pwr_dvfs_controller;

   localparam int S = 4;
   localparam int T = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_mode = 2'b00;
   logic       req_ready;
   logic       vreg_req;
   logic [1:0] vreg_level;
   logic       vreg_ack = 1'b0;
   logic       pll_req;
   logic [1:0] pll_mode;
   logic       pll_lock = 1'b0;
   logic [1:0] performance_mode;
   logic       busy;
   logic       error;
   logic       err_src;
   logic       err_clr = 1'b0;

   int compared = 0;
   int mismatched = 0;

   // Model of what the controller has committed / driven to the external parts.
   logic [1:0] m_mode = 2'b00;
   logic [1:0] m_vlvl = 2'b00;
   logic [1:0] m_pll  = 2'b00;

   pwr_dvfs_controller #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_mode         (req_mode),
      .req_ready        (req_ready),
      .vreg_req         (vreg_req),
      .vreg_level       (vreg_level),
      .vreg_ack         (vreg_ack),
      .pll_req          (pll_req),
      .pll_mode         (pll_mode),
      .pll_lock         (pll_lock),
      .performance_mode (performance_mode),
      .busy             (busy),
      .error            (error),
      .err_src          (err_src),
      .err_clr          (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic test_reset();
      logic [11:0] obs;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      obs = {performance_mode, vreg_level, pll_mode, vreg_req, pll_req, busy, error, err_src, req_ready};
      compared++;
      if (obs !== 12'b000000_000001) begin
         mismatched++;
         $display("FAIL reset_hold: outputs %b expected %b", obs, 12'b000000_000001);
      end
      rst = 1'b0;
      @(negedge clk);
      obs = {performance_mode, vreg_level, pll_mode, vreg_req, pll_req, busy, error, err_src, req_ready};
      compared++;
      if (obs !== 12'b000000_000001) begin
         mismatched++;
         $display("FAIL reset_release: outputs %b expected %b", obs, 12'b000000_000001);
      end
      m_mode = 2'b00; m_vlvl = 2'b00; m_pll = 2'b00;
   endtask

   // Runs one complete transition starting at a negedge; ends at the negedge of the first idle cycle.
   // dv/dp: cycles between the request rising and the ack/lock returning.
   task automatic run_txn(input logic [1:0] tgt, input int dv, input int dp,
                          input bit hold, input logic [1:0] hold_mode, input string name);
      logic [1:0] start;
      int n, end_n, exp_end, first_v, last_v, first_p, last_p, vcnt, pcnt;
      int bad_lvl, mid_chg, busy_rdy;
      bit ord_ok;
      start = m_mode;
      n = 0; end_n = -1; first_v = -1; last_v = -1; first_p = -1; last_p = -1;
      vcnt = 0; pcnt = 0; bad_lvl = 0; mid_chg = 0; busy_rdy = 0;

      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ready_before: req_ready %b expected 1", name, req_ready);
      end
      req_valid = 1'b1;
      req_mode  = tgt;
      @(posedge clk);
      while (end_n < 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (hold) begin
            req_valid = 1'b1;
            req_mode  = hold_mode;
         end else begin
            req_valid = 1'b0;
         end
         if (vreg_req) begin
            if (first_v < 0) first_v = n;
            last_v = n;
            if (vreg_level !== tgt) bad_lvl++;
         end
         if (pll_req) begin
            if (first_p < 0) first_p = n;
            last_p = n;
            if (pll_mode !== tgt) bad_lvl++;
         end
         if (busy && req_ready) busy_rdy++;
         if (!busy) end_n = n;
         else if (performance_mode !== start) mid_chg++;
         vcnt = vreg_req ? vcnt + 1 : 0;
         pcnt = pll_req ? pcnt + 1 : 0;
         vreg_ack = vreg_req ? (vcnt == dv + 1) : ($urandom_range(3) == 0);
         pll_lock = pll_req ? (pcnt == dp + 1) : ($urandom_range(3) == 0);
      end

      // Phase model: each handshake phase lasts delay+1 cycles, then DONE, then first idle sample.
      if (tgt > start) begin
         exp_end = (dv + 1) + S + (dp + 1) + 1 + 1;
         ord_ok  = (first_v == 1) && (last_v == dv + 1) &&
                   (first_p == last_v + S + 1) && (last_p == first_p + dp);
      end else if (tgt < start) begin
         exp_end = (dp + 1) + (dv + 1) + 1 + 1;
         ord_ok  = (first_p == 1) && (last_p == dp + 1) &&
                   (first_v == last_p + 1) && (last_v == first_v + dv);
      end else begin
         exp_end = 2;
         ord_ok  = (first_v < 0) && (first_p < 0);
      end
      if (tgt != start) begin
         m_vlvl = tgt;
         m_pll  = tgt;
      end
      m_mode = tgt;

      compared++;
      if (end_n !== exp_end) begin
         mismatched++;
         $display("FAIL %s latency: idle at cycle %0d expected %0d", name, end_n, exp_end);
      end
      compared++;
      if (performance_mode !== m_mode) begin
         mismatched++;
         $display("FAIL %s perf_mode: got %b expected %b", name, performance_mode, m_mode);
      end
      compared++;
      if (ord_ok !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ordering: vreg %0d..%0d pll %0d..%0d", name, first_v, last_v, first_p, last_p);
      end
      compared++;
      if ({mid_chg, bad_lvl, busy_rdy} !== {32'd0, 32'd0, 32'd0}) begin
         mismatched++;
         $display("FAIL %s sequence: mid_changes %0d bad_levels %0d ready_while_busy %0d expected 0 0 0",
                  name, mid_chg, bad_lvl, busy_rdy);
      end
      compared++;
      if ({vreg_level, pll_mode} !== {m_vlvl, m_pll}) begin
         mismatched++;
         $display("FAIL %s levels: vreg %b pll %b expected %b %b", name, vreg_level, pll_mode, m_vlvl, m_pll);
      end
      if (tgt > start) begin
         compared++;
         if (first_p - last_v - 1 !== S) begin
            mismatched++;
            $display("FAIL %s settle_gap: got %0d expected %0d", name, first_p - last_v - 1, S);
         end
      end
   endtask

   task automatic test_timeout(input logic [1:0] tgt, input bit clr_same, input string name);
      logic [1:0] start;
      int n, hi_v, hi_p, blocked;
      bit up, fell;
      start = m_mode;
      up = (tgt > start);
      n = 0; hi_v = 0; hi_p = 0; fell = 0; blocked = 0;
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ready_before: req_ready %b expected 1", name, req_ready);
      end
      vreg_ack = 1'b0; pll_lock = 1'b0;
      req_valid = 1'b1; req_mode = tgt;
      @(posedge clk);
      while (!fell && n < 100) begin
         @(negedge clk);
         n++;
         req_valid = 1'b0;
         err_clr = 1'b0;
         if (vreg_req) hi_v++;
         if (pll_req) hi_p++;
         if (!vreg_req && !pll_req && n > 1) fell = 1;
         else if (clr_same && (hi_v + hi_p) == T) err_clr = 1'b1;
      end
      if (up) m_vlvl = tgt;
      else    m_pll  = tgt;

      compared++;
      if ((up ? hi_v : hi_p) !== T || (up ? hi_p : hi_v) !== 0) begin
         mismatched++;
         $display("FAIL %s req_duration: vreg %0d pll %0d cycles, expected %0d on %s only",
                  name, hi_v, hi_p, T, up ? "vreg" : "pll");
      end
      compared++;
      if ({error, err_src} !== {1'b1, up ? 1'b0 : 1'b1}) begin
         mismatched++;
         $display("FAIL %s error_flags: error/src %b%b expected 1%b", name, error, err_src, up ? 1'b0 : 1'b1);
      end
      compared++;
      if ({req_ready, busy} !== 2'b00) begin
         mismatched++;
         $display("FAIL %s ready_busy: %b%b expected 00", name, req_ready, busy);
      end
      compared++;
      if ({performance_mode, vreg_level, pll_mode} !== {m_mode, m_vlvl, m_pll}) begin
         mismatched++;
         $display("FAIL %s held_state: mode/vreg/pll %b %b %b expected %b %b %b", name,
                  performance_mode, vreg_level, pll_mode, m_mode, m_vlvl, m_pll);
      end

      req_valid = 1'b1; req_mode = tgt;
      repeat (3) begin
         @(negedge clk);
         if (busy || req_ready || vreg_req || pll_req) blocked++;
      end
      req_valid = 1'b0;
      compared++;
      if (blocked !== 0) begin
         mismatched++;
         $display("FAIL %s blocked_in_error: %0d active cycles expected 0", name, blocked);
      end

      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      compared++;
      if ({error, req_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL %s err_clr: error/ready %b%b expected 01", name, error, req_ready);
      end
   endtask

   task automatic test_reset_mid();
      int n, vcnt;
      logic [11:0] obs;
      bit in_settle;
      n = 0; vcnt = 0;
      req_valid = 1'b1; req_mode = 2'b10;
      @(posedge clk);
      while (n < 5) begin
         @(negedge clk);
         n++;
         req_valid = 1'b0;
         vcnt = vreg_req ? vcnt + 1 : 0;
         vreg_ack = vreg_req && (vcnt == 2);
         pll_lock = 1'b0;
      end
      in_settle = busy && !vreg_req && !pll_req && (vreg_level == 2'b10);
      compared++;
      if (in_settle !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_mid in_settle: busy %b vreg_req %b pll_req %b level %b expected 1 0 0 10",
                  busy, vreg_req, pll_req, vreg_level);
      end
      #2 rst = 1'b1;
      #1;
      obs = {performance_mode, vreg_level, pll_mode, vreg_req, pll_req, busy, error, err_src, req_ready};
      compared++;
      if (obs !== 12'b000000_000001) begin
         mismatched++;
         $display("FAIL reset_mid async: outputs %b expected %b", obs, 12'b000000_000001);
      end
      @(negedge clk);
      rst = 1'b0;
      vreg_ack = 1'b0;
      m_mode = 2'b00; m_vlvl = 2'b00; m_pll = 2'b00;
      run_txn(2'b01, 2, 3, 1'b0, 2'b00, "after_reset_00_01");
   endtask

   task automatic test_up();
      run_txn(2'b10, 3, 5, 1'b0, 2'b00, "up_00_10");
   endtask

   task automatic test_same_mode();
      run_txn(2'b10, 1, 1, 1'b0, 2'b00, "same_10");
   endtask

   task automatic test_down();
      run_txn(2'b11, 2, 2, 1'b0, 2'b00, "up_10_11");
      run_txn(2'b01, 4, 3, 1'b0, 2'b00, "down_11_01");
   endtask

   task automatic test_back_to_back();
      run_txn(2'b00, 1, 2, 1'b0, 2'b00, "down_01_00");
      run_txn(2'b01, 2, 3, 1'b1, 2'b11, "bp_first_00_01");
      run_txn(2'b11, 1, 1, 1'b0, 2'b00, "bp_second_01_11");
   endtask

   task automatic test_timeouts();
      test_timeout(2'b00, 1'b1, "pll_timeout_clr_same");
      run_txn(2'b00, 2, 2, 1'b0, 2'b00, "down_11_00");
      test_timeout(2'b10, 1'b0, "vreg_timeout");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_txn(2'($urandom_range(3)), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                 1'b0, 2'b00, "random");
      end
   endtask

   initial begin
      test_reset();
      test_up();
      test_same_mode();
      test_down();
      test_back_to_back();
      test_timeouts();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
